// File: rtl/wt_mem_req_arbiter.sv
// Merges N cache request channels onto one memory port with global tag remapping,
// routes returns back by tag, and broadcasts invalidations. Option: WT_ARB_PRIO_EN.
module wt_mem_req_arbiter #(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned LocalIdWidth   = 2,
  parameter int unsigned PayloadWidth   = 128,
  parameter int unsigned RtrnWidth      = 128,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned InvalAddrWidth = 64,
  localparam int unsigned TagWidth      = $clog2(MaxOutstanding),
  localparam int unsigned ChanWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels-1:0]           chan_req_i,
  input  logic [NumChannels*LocalIdWidth-1:0] chan_req_id_i,
  input  logic [NumChannels*PayloadWidth-1:0] chan_req_data_i,
  output logic [NumChannels-1:0]           chan_req_ack_o,
  output logic [NumChannels-1:0]           chan_rtrn_vld_o,
  output logic [LocalIdWidth-1:0]          chan_rtrn_id_o,
  output logic [RtrnWidth-1:0]             chan_rtrn_data_o,
  output logic [NumChannels-1:0]           chan_inval_vld_o,
  input  logic [NumChannels-1:0]           chan_inval_ack_i,
  output logic [InvalAddrWidth-1:0]        chan_inval_addr_o,
  output logic                             mem_req_o,
  input  logic                             mem_ack_i,
  output logic [TagWidth-1:0]              mem_tag_o,
  output logic [PayloadWidth-1:0]          mem_data_o,
  input  logic                             mem_rtrn_vld_i,
  input  logic [TagWidth-1:0]              mem_rtrn_tag_i,
  input  logic [RtrnWidth-1:0]             mem_rtrn_data_i,
  input  logic                             inval_valid_i,
  input  logic [InvalAddrWidth-1:0]        inval_addr_i,
  output logic                             inval_ready_o,
  output logic [TagWidth:0]                outstanding_o,
  output logic                             tag_err_o
);

  localparam logic [NumChannels-1:0] Ch0Mask = NumChannels'(1);

  typedef enum logic [0:0] {StIdle, StBcast} inval_state_e;

  logic [MaxOutstanding-1:0] busy_q, busy_d;
  logic [ChanWidth-1:0]      tbl_chan_q [MaxOutstanding];
  logic [LocalIdWidth-1:0]   tbl_id_q   [MaxOutstanding];
  logic [ChanWidth-1:0]      rr_q;
  logic [TagWidth:0]         outstanding_q;
  logic                      mem_req_q;
  logic [TagWidth-1:0]       mem_tag_q;
  logic [PayloadWidth-1:0]   mem_data_q;
  logic [NumChannels-1:0]    rtrn_vld_q;
  logic [LocalIdWidth-1:0]   rtrn_id_q;
  logic [RtrnWidth-1:0]      rtrn_data_q;
  logic                      tag_err_q;
  inval_state_e              inval_state_q;
  logic [NumChannels-1:0]    inval_vld_q;
  logic [InvalAddrWidth-1:0] inval_addr_q;

  logic                      free_found;
  logic [TagWidth-1:0]       free_tag;
  logic [NumChannels-1:0]    rr_req;
  logic                      rr_found;
  logic [ChanWidth-1:0]      rr_idx;
  logic                      gnt_found;
  logic [ChanWidth-1:0]      gnt_idx;
  logic                      accept;
  logic                      rtrn_hit;
  logic [NumChannels-1:0]    inval_left;

  // Lowest-index free tag, from the pre-edge busy vector.
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = MaxOutstanding - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_tag   = TagWidth'(i);
      end
    end
  end

  always_comb begin
    int cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int off = 0; off < int'(NumChannels); off++) begin
      cand = (int'(rr_q) + off) % int'(NumChannels);
      if (!rr_found && rr_req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = ChanWidth'(cand);
      end
    end
  end

`ifdef WT_ARB_PRIO_EN
  logic [3:0] starve_q;
  logic       others_req;
  logic       prio0;

  // Channel 0 wins unless it has starved the others for 15 grants in a row.
  assign others_req = |(chan_req_i & ~Ch0Mask);
  assign prio0      = chan_req_i[0] && !(starve_q == 4'd15 && others_req);
  assign rr_req     = prio0 ? '0 : (chan_req_i & ~Ch0Mask);
  assign gnt_found  = prio0 || rr_found;
  assign gnt_idx    = prio0 ? '0 : rr_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= 4'd0;
    end else if (accept) begin
      if (gnt_idx != '0) begin
        starve_q <= 4'd0;
      end else if (others_req) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`else
  assign rr_req    = chan_req_i;
  assign gnt_found = rr_found;
  assign gnt_idx   = rr_idx;
`endif

  assign accept         = (!mem_req_q || mem_ack_i) && free_found && gnt_found;
  assign chan_req_ack_o = accept ? (Ch0Mask << gnt_idx) : '0;
  assign rtrn_hit       = mem_rtrn_vld_i && busy_q[mem_rtrn_tag_i];

  always_comb begin
    busy_d = busy_q;
    if (rtrn_hit) busy_d[mem_rtrn_tag_i] = 1'b0;
    if (accept)   busy_d[free_tag] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      rr_q          <= '0;
      outstanding_q <= '0;
      mem_req_q     <= 1'b0;
      mem_tag_q     <= '0;
      mem_data_q    <= '0;
      rtrn_vld_q    <= '0;
      rtrn_id_q     <= '0;
      rtrn_data_q   <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_q + (TagWidth+1)'(accept) - (TagWidth+1)'(rtrn_hit);
      if (accept) begin
        mem_req_q  <= 1'b1;
        mem_tag_q  <= free_tag;
        mem_data_q <= chan_req_data_i[gnt_idx*PayloadWidth +: PayloadWidth];
        rr_q       <= (int'(gnt_idx) == int'(NumChannels) - 1) ? '0 : gnt_idx + 1'b1;
      end else if (mem_ack_i) begin
        mem_req_q <= 1'b0;
      end
      rtrn_vld_q <= rtrn_hit ? (Ch0Mask << tbl_chan_q[mem_rtrn_tag_i]) : '0;
      if (rtrn_hit) begin
        rtrn_id_q   <= tbl_id_q[mem_rtrn_tag_i];
        rtrn_data_q <= mem_rtrn_data_i;
      end
      if (mem_rtrn_vld_i && !busy_q[mem_rtrn_tag_i]) tag_err_q <= 1'b1;
    end
  end

  // Table entries are only read while their busy bit is set, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tbl_chan_q[free_tag] <= gnt_idx;
      tbl_id_q[free_tag]   <= chan_req_id_i[gnt_idx*LocalIdWidth +: LocalIdWidth];
    end
  end

  assign inval_left = inval_vld_q & ~chan_inval_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inval_state_q <= StIdle;
      inval_vld_q   <= '0;
      inval_addr_q  <= '0;
    end else begin
      unique case (inval_state_q)
        StIdle: begin
          if (inval_valid_i) begin
            inval_state_q <= StBcast;
            inval_vld_q   <= '1;
            inval_addr_q  <= inval_addr_i;
          end
        end
        StBcast: begin
          inval_vld_q <= inval_left;
          if (inval_left == '0) inval_state_q <= StIdle;
        end
        default: inval_state_q <= StIdle;
      endcase
    end
  end

  assign chan_rtrn_vld_o   = rtrn_vld_q;
  assign chan_rtrn_id_o    = rtrn_id_q;
  assign chan_rtrn_data_o  = rtrn_data_q;
  assign chan_inval_vld_o  = inval_vld_q;
  assign chan_inval_addr_o = inval_addr_q;
  assign inval_ready_o     = (inval_state_q == StIdle);
  assign mem_req_o         = mem_req_q;
  assign mem_tag_o         = mem_tag_q;
  assign mem_data_o        = mem_data_q;
  assign outstanding_o     = outstanding_q;
  assign tag_err_o         = tag_err_q;

endmodule
